// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one SRAM-style bus between an instruction-fetch and a data requester,
// one outstanding transaction at a time. Define ARB_RR_EN for round-robin tie-breaking.
module sram_arbiter #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_req,
    input  logic [DW-1:0] i_addr,
    output logic          i_addr_ok,
    output logic          i_data_ok,
    output logic [DW-1:0] i_rdata,
    input  logic          d_req,
    input  logic          d_wr,
    input  logic [3:0]    d_wstrb,
    input  logic [DW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_addr_ok,
    output logic          d_data_ok,
    output logic [DW-1:0] d_rdata,
    output logic          m_req,
    output logic          m_wr,
    output logic [3:0]    m_wstrb,
    output logic [DW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic          m_addr_ok,
    input  logic          m_data_ok,
    input  logic [DW-1:0] m_rdata,
    output logic          busy
);
    localparam logic [1:0] IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2;
    localparam logic OWN_I = 1'b0;

    logic [1:0]    state_q, state_d;
    logic          owner_q, owner_d, wr_q, wr_d;
    logic [3:0]    wstrb_q, wstrb_d;
    logic [DW-1:0] addr_q, addr_d, wdata_q, wdata_d;
    logic          grant, sel_dat, addr_ok, data_ok;

    assign grant = state_q == IDLE && (i_req || d_req);

`ifdef ARB_RR_EN
    logic last_q;
    // On a tie, serve whoever did not win the previous grant.
    assign sel_dat = d_req && (!i_req || last_q == OWN_I);
    always_ff @(posedge clk or negedge rst)
        if (!rst) last_q <= OWN_I;
        else if (grant) last_q <= sel_dat;
`else
    assign sel_dat = d_req;
`endif

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        wr_d    = wr_q;
        wstrb_d = wstrb_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (grant) begin
            state_d = ADDR;
            owner_d = sel_dat;
            wr_d    = sel_dat & d_wr;
            wstrb_d = sel_dat ? d_wstrb : 4'h0;
            addr_d  = sel_dat ? d_addr : i_addr;
            wdata_d = sel_dat ? d_wdata : '0;
        end else if (state_q == ADDR && m_addr_ok) state_d = m_data_ok ? IDLE : DATA;
        else if (state_q == DATA && m_data_ok) state_d = IDLE;
        else if (state_q == 2'd3) state_d = IDLE;
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state_q <= IDLE;
            owner_q <= OWN_I;
            wr_q    <= 1'b0;
            wstrb_q <= 4'h0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            wr_q    <= wr_d;
            wstrb_q <= wstrb_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end

    // data_ok in ADDR only counts when the address is accepted in the same cycle.
    assign addr_ok   = state_q == ADDR && m_addr_ok;
    assign data_ok   = (addr_ok && m_data_ok) || (state_q == DATA && m_data_ok);
    assign i_addr_ok = addr_ok && owner_q == OWN_I;
    assign i_data_ok = data_ok && owner_q == OWN_I;
    assign d_addr_ok = addr_ok && owner_q != OWN_I;
    assign d_data_ok = data_ok && owner_q != OWN_I;
    assign i_rdata   = i_data_ok ? m_rdata : '0;
    assign d_rdata   = d_data_ok ? m_rdata : '0;
    assign m_req     = state_q == ADDR;
    assign m_wr      = wr_q;
    assign m_wstrb   = wstrb_q;
    assign m_addr    = addr_q;
    assign m_wdata   = wdata_q;
    assign busy      = state_q != IDLE;
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed scenarios plus randomized transactions against a transaction-level model.
module tb_sram_arbiter;
    logic clk = 1'b0, rst = 1'b0;
    logic i_req = 1'b0, d_req = 1'b0, d_wr = 1'b0, m_addr_ok = 1'b0, m_data_ok = 1'b0;
    logic [3:0] d_wstrb = 4'h0;
    logic [31:0] i_addr = 32'h0, d_addr = 32'h0, d_wdata = 32'h0, m_rdata = 32'h0;
    logic i_addr_ok, i_data_ok, d_addr_ok, d_data_ok, m_req, m_wr, busy;
    logic [3:0] m_wstrb;
    logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
    logic [5:0] ctl;
    int checks = 0, errors = 0;
    logic last_d = 1'b0;
`ifdef ARB_RR_EN
    localparam logic RR = 1'b1;
`else
    localparam logic RR = 1'b0;
`endif

    always #5 clk = ~clk;

    sram_arbiter #(.DW(32)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_addr_ok(i_addr_ok), .i_data_ok(i_data_ok), .i_rdata(i_rdata),
        .d_req(d_req), .d_wr(d_wr), .d_wstrb(d_wstrb), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok), .d_rdata(d_rdata),
        .m_req(m_req), .m_wr(m_wr), .m_wstrb(m_wstrb), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata), .busy(busy)
    );

    assign ctl = {m_req, busy, i_addr_ok, i_data_ok, d_addr_ok, d_data_ok};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble();
        i_req = 1'($urandom); d_req = 1'($urandom); d_wr = 1'($urandom); d_wstrb = 4'($urandom);
        i_addr = $urandom; d_addr = $urandom; d_wdata = $urandom;
    endtask

    task automatic do_reset();
        i_req = 0; d_req = 0; m_addr_ok = 0; m_data_ok = 0;
        rst = 0;
        step();
        rst = 1;
        last_d = 0;
    endtask

    task automatic test_reset();
        rst = 0;
        #1;
        checks++;
        if (ctl !== 6'b0 || m_addr !== 0 || m_wdata !== 0 || m_wstrb !== 0 || m_wr !== 0 || i_rdata !== 0 || d_rdata !== 0) begin
            errors++;
            $display("FAIL reset ctl=%b addr=%h wdata=%h wstrb=%h wr=%b expected all zero", ctl, m_addr, m_wdata, m_wstrb, m_wr);
        end
        step();
        rst = 1;
    endtask

    task automatic test_fetch();
        i_req = 1; i_addr = 32'hBFC00000;
        @(negedge clk);
        checks++; if (ctl !== 6'b000000) begin errors++; $display("FAIL fetch_c0 ctl=%b exp 000000", ctl); end
        step(); i_req = 0; i_addr = 32'h0;
        @(negedge clk);
        checks++; if (ctl !== 6'b110000 || m_addr !== 32'hBFC00000 || m_wr !== 0) begin errors++; $display("FAIL fetch_c1 ctl=%b addr=%h wr=%b exp 110000 bfc00000 0", ctl, m_addr, m_wr); end
        step(); m_addr_ok = 1;
        @(negedge clk);
        checks++; if (ctl !== 6'b111000) begin errors++; $display("FAIL fetch_c2 ctl=%b exp 111000", ctl); end
        step(); m_addr_ok = 0;
        @(negedge clk);
        checks++; if (ctl !== 6'b010000) begin errors++; $display("FAIL fetch_c3 ctl=%b exp 010000", ctl); end
        step(); m_data_ok = 1; m_rdata = 32'h3C080001;
        @(negedge clk);
        checks++; if (ctl !== 6'b010100 || i_rdata !== 32'h3C080001 || d_rdata !== 0) begin errors++; $display("FAIL fetch_c4 ctl=%b i_rdata=%h d_rdata=%h exp 010100 3c080001 0", ctl, i_rdata, d_rdata); end
        step(); m_data_ok = 0;
        @(negedge clk);
        checks++; if (ctl !== 6'b000000) begin errors++; $display("FAIL fetch_c5 ctl=%b exp 000000", ctl); end
        step();
        last_d = 0;
    endtask

    task automatic test_priority();
        i_req = 1; i_addr = 32'h00400010;
        d_req = 1; d_wr = 1; d_addr = 32'h80001000; d_wstrb = 4'hF; d_wdata = 32'hDEADBEEF;
        step(); d_req = 0; d_wr = 0; d_wstrb = 0; d_wdata = 0; m_addr_ok = 1;
        @(negedge clk);
        checks++; if (ctl !== 6'b110010 || m_addr !== 32'h80001000 || m_wr !== 1 || m_wstrb !== 4'hF || m_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL prio_data ctl=%b addr=%h wr=%b wstrb=%h wdata=%h", ctl, m_addr, m_wr, m_wstrb, m_wdata); end
        step(); m_addr_ok = 0; m_data_ok = 1;
        @(negedge clk);
        checks++; if (ctl !== 6'b010001) begin errors++; $display("FAIL prio_ddone ctl=%b exp 010001", ctl); end
        step(); m_data_ok = 0;
        @(negedge clk);
        checks++; if (ctl !== 6'b000000) begin errors++; $display("FAIL prio_bubble ctl=%b exp 000000", ctl); end
        step(); i_req = 0; m_addr_ok = 1; m_data_ok = 1; m_rdata = 32'h24020007;
        @(negedge clk);
        checks++; if (ctl !== 6'b111100 || m_addr !== 32'h00400010 || m_wr !== 0 || m_wstrb !== 0 || m_wdata !== 0 || i_rdata !== 32'h24020007) begin errors++; $display("FAIL prio_fetch ctl=%b addr=%h wr=%b wstrb=%h rdata=%h", ctl, m_addr, m_wr, m_wstrb, i_rdata); end
        step(); m_addr_ok = 0; m_data_ok = 0;
        last_d = 0;
    endtask

    task automatic test_same_cycle();
        d_req = 1; d_wr = 0; d_addr = 32'h80002000;
        step(); d_req = 0; m_addr_ok = 1; m_data_ok = 1; m_rdata = 32'h12345678;
        @(negedge clk);
        checks++; if (ctl !== 6'b110011 || d_rdata !== 32'h12345678 || i_rdata !== 0) begin errors++; $display("FAIL same_cycle ctl=%b d_rdata=%h i_rdata=%h exp 110011 12345678 0", ctl, d_rdata, i_rdata); end
        step(); m_addr_ok = 0; m_data_ok = 0;
        @(negedge clk);
        checks++; if (ctl !== 6'b000000) begin errors++; $display("FAIL same_cycle_idle ctl=%b exp 000000", ctl); end
        step();
        last_d = 1;
    endtask

    task automatic test_reset_mid();
        i_req = 1; i_addr = 32'h00001234;
        step(); i_req = 0; m_addr_ok = 1;
        step(); m_addr_ok = 0;
        @(negedge clk);
        checks++; if (ctl !== 6'b010000) begin errors++; $display("FAIL rstmid_data ctl=%b exp 010000", ctl); end
        #2 rst = 0;
        #1;
        checks++; if (ctl !== 6'b000000 || m_addr !== 0) begin errors++; $display("FAIL rstmid_async ctl=%b addr=%h exp 000000 0", ctl, m_addr); end
        step(); rst = 1; last_d = 0;
        m_data_ok = 1; m_addr_ok = 1; m_rdata = 32'hCAFEF00D;
        @(negedge clk);
        checks++; if (ctl !== 6'b000000 || i_rdata !== 0 || d_rdata !== 0) begin errors++; $display("FAIL rstmid_late ctl=%b i_rdata=%h exp 000000 0", ctl, i_rdata); end
        step(); m_data_ok = 0; m_addr_ok = 0;
    endtask

    task automatic test_hold_order();
        logic ed;
        do_reset();
        i_req = 1; i_addr = 32'h11110000; d_req = 1; d_wr = 0; d_addr = 32'h22220000;
        for (int t = 0; t < 4; t++) begin
            ed = !RR || !last_d;
            @(negedge clk);
            checks++; if (ctl !== 6'b000000) begin errors++; $display("FAIL hold_idle%0d ctl=%b exp 000000", t, ctl); end
            step(); m_addr_ok = 1; m_data_ok = 1; m_rdata = 32'(t);
            @(negedge clk);
            checks++;
            if (m_addr !== (ed ? 32'h22220000 : 32'h11110000) || ctl !== {2'b11, ~ed, ~ed, ed, ed}) begin
                errors++; $display("FAIL hold_grant%0d addr=%h ctl=%b exp_data_owner=%b", t, m_addr, ctl, ed);
            end
            step(); m_addr_ok = 0; m_data_ok = 0;
            last_d = ed;
        end
        i_req = 0; d_req = 0;
        step();
    endtask

    task automatic test_random();
        logic [1:0] rq;
        logic ed, ew, aok, dok;
        logic [3:0] es;
        logic [31:0] ea, ewd;
        logic [5:0] ex;
        int na, nd;
        for (int t = 0; t < 60; t++) begin
            rq = 2'($urandom_range(1, 3));
            scramble();
            i_req = rq[0]; d_req = rq[1];
            m_addr_ok = 1'($urandom); m_data_ok = 1'($urandom); m_rdata = $urandom;
            ed = d_req && (!i_req || !RR || !last_d);
            ea = ed ? d_addr : i_addr;
            ew = ed & d_wr;
            es = ed ? d_wstrb : 4'h0;
            ewd = ed ? d_wdata : 32'h0;
            last_d = ed;
            @(negedge clk);
            checks++; if (ctl !== 6'b000000 || i_rdata !== 0 || d_rdata !== 0) begin errors++; $display("FAIL rnd_idle%0d ctl=%b exp 000000", t, ctl); end
            step();
            na = $urandom_range(0, 3);
            nd = $urandom_range(0, 3);
            for (int k = 0; k <= na; k++) begin
                scramble();
                aok = k == na;
                dok = aok && nd == 0;
                m_addr_ok = aok; m_data_ok = aok ? dok : 1'($urandom); m_rdata = $urandom;
                ex = {2'b11, ~ed & aok, ~ed & dok, ed & aok, ed & dok};
                @(negedge clk);
                checks++;
                if (ctl !== ex || m_addr !== ea || m_wr !== ew || m_wstrb !== es || m_wdata !== ewd) begin
                    errors++; $display("FAIL rnd_addr%0d ctl=%b/%b addr=%h/%h wr=%b/%b wstrb=%h/%h wdata=%h/%h", t, ctl, ex, m_addr, ea, m_wr, ew, m_wstrb, es, m_wdata, ewd);
                end
                checks++;
                if (i_rdata !== ((!ed && dok) ? m_rdata : 32'h0) || d_rdata !== ((ed && dok) ? m_rdata : 32'h0)) begin
                    errors++; $display("FAIL rnd_addr_rdata%0d i=%h d=%h m=%h owner_d=%b ok=%b", t, i_rdata, d_rdata, m_rdata, ed, dok);
                end
                step();
            end
            for (int k = 1; k <= nd; k++) begin
                scramble();
                dok = k == nd;
                m_addr_ok = 1'($urandom); m_data_ok = dok; m_rdata = $urandom;
                ex = {2'b01, 1'b0, ~ed & dok, 1'b0, ed & dok};
                @(negedge clk);
                checks++;
                if (ctl !== ex || i_rdata !== ((!ed && dok) ? m_rdata : 32'h0) || d_rdata !== ((ed && dok) ? m_rdata : 32'h0)) begin
                    errors++; $display("FAIL rnd_data%0d ctl=%b/%b i=%h d=%h m=%h", t, ctl, ex, i_rdata, d_rdata, m_rdata);
                end
                step();
            end
        end
        i_req = 0; d_req = 0; m_addr_ok = 0; m_data_ok = 0;
        step();
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_priority();
        test_same_cycle();
        test_reset_mid();
        test_hold_order();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter DW, default 32, data/address width.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset; asynchronous assertion, active-low.
REQ-004 SHALL have port i_req  input  1  instruction-fetch request.
REQ-005 SHALL have port i_addr  input  DW  fetch address.
REQ-006 SHALL have port i_addr_ok / i_data_ok  output  1 each  fetch address accepted / fetch data returned.
REQ-007 SHALL have port i_rdata  output  DW  fetch read data.
REQ-008 SHALL have port d_req, d_wr  input  1 each  data request / write (1) or read (0).
REQ-009 SHALL have port d_wstrb  input  4  byte write strobes.
REQ-010 SHALL have port d_addr, d_wdata  input  DW each  data address / write data.
REQ-011 SHALL have port d_addr_ok / d_data_ok  output  1 each  data address accepted / data completed.
REQ-012 SHALL have port d_rdata  output  DW  data read data.
REQ-013 SHALL have port m_req, m_wr  output  1 each  shared-bus request / write.
REQ-014 SHALL have port m_wstrb  output  4  shared-bus byte strobes.
REQ-015 SHALL have port m_addr, m_wdata  output  DW each  shared-bus address / write data.
REQ-016 SHALL have port m_addr_ok, m_data_ok  input  1 each  slave address accept / data done.
REQ-017 SHALL have port m_rdata  input  DW  slave read data.
REQ-018 SHALL have port busy  output  1  high whenever state != IDLE.

Function
REQ-019 SHALL implement FSM IDLE -> ADDR -> DATA -> IDLE; one outstanding transaction maximum.
REQ-020 IDLE: if any request is pending, SHALL select a winner, latch owner, wr, wstrb, addr, wdata into registers, and enter ADDR next cycle; else stay IDLE.
REQ-021 Fixed policy: d_req SHALL win over i_req on a tie; i_req alone wins; i_* fields latched with wr=0, wstrb=0.
REQ-022 m_req SHALL be 1 exactly while in ADDR; m_wr/m_wstrb/m_addr/m_wdata SHALL come from latched registers only.
REQ-023 ADDR: on m_addr_ok=1, owner's x_addr_ok SHALL pulse that same cycle (combinational) and FSM SHALL enter DATA.
REQ-024 ADDR with m_addr_ok=1 and m_data_ok=1 in the same cycle: owner SHALL see addr_ok and data_ok together, FSM SHALL return to IDLE.
REQ-025 DATA: on m_data_ok=1, owner's x_data_ok SHALL pulse that cycle with x_rdata=m_rdata, FSM SHALL return to IDLE.
REQ-026 Non-owner addr_ok/data_ok SHALL be 0 and its rdata SHALL be 0 at all times.
REQ-027 m_addr_ok/m_data_ok SHALL be ignored in IDLE, and m_data_ok SHALL be ignored in ADDR unless m_addr_ok is high in that cycle.
REQ-028 Requester deasserting req after grant SHALL NOT abort the latched transaction.
REQ-029 Minimum latency: req sampled in cycle N -> m_req in N+1; back-to-back transactions SHALL have one IDLE bubble.

Reset
REQ-030 On rst=0, FSM SHALL go to IDLE immediately, with m_req=0, busy=0, all *_addr_ok/*_data_ok=0, all latched registers=0.
REQ-031 Reset mid-transaction SHALL drop the transaction; late slave responses after release SHALL be ignored per REQ-027.

Configuration
REQ-032 With macro ARB_RR_EN defined, ties SHALL be resolved round-robin: last_owner register updated at each grant; tie goes to the requester that is not last_owner; last_owner resets to INST, so the first tie goes to data.
REQ-033 Without ARB_RR_EN, last_owner SHALL NOT exist and REQ-021 fixed data priority SHALL apply.

Verification
REQ-034 i_req=1, i_addr=0xBFC00000; slave gives addr_ok at cycle 2, data_ok at cycle 4 with rdata=0x3C080001 -> m_addr=0xBFC00000, m_wr=0, i_addr_ok at cycle 2, i_data_ok plus i_rdata=0x3C080001 at cycle 4, busy for cycles 1-4.
REQ-035 i_req and d_req both high, d_wr=1, d_addr=0x80001000, d_wstrb=0xF, d_wdata=0xDEADBEEF -> data served first with m_wstrb=0xF, then fetch after one IDLE bubble, with ARB_RR_EN undefined.
REQ-036 ARB_RR_EN defined, both requesters held high for 4 transactions -> grant order is D, I, D, I.
REQ-037 Slave asserts m_addr_ok and m_data_ok in the same cycle for a d_wr=0 read of 0x12345678 -> d_addr_ok, d_data_ok and d_rdata=0x12345678 in that one cycle, next state IDLE.
REQ-038 rst=0 asserted while in DATA, then released; slave then pulses m_data_ok -> no x_data_ok, m_req=0, busy=0.
